// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit 3-sample majority vote, per-character error tags and a show-ahead
// receive FIFO with sticky overrun. Define UART_RX_TIMEOUT_EN to add the idle timeout pulse.
module uart_rx_fifo #(
    parameter int unsigned BTU_WIDTH   = 21,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned LEVEL_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset_in,
    input  logic [BTU_WIDTH-1:0]   btu,
    input  logic [1:0]             csize,
    input  logic                   parenb,
    input  logic                   parodd,
    input  logic                   rxd,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [7:0]             rd_char,
    output logic                   rd_parity_err,
    output logic                   rd_frame_err,
    output logic                   rd_break,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   overrun,
    input  logic                   overrun_clr
`ifdef UART_RX_TIMEOUT_EN
    ,
    output logic                   timeout
`endif
);
    localparam int unsigned AW = LEVEL_WIDTH - 1;
    localparam logic [BTU_WIDTH-1:0] BtuOne = BTU_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] PtrOne = LEVEL_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] Depth = LEVEL_WIDTH'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdleWait, StHunt, StStart, StData, StParity, StStop} state_e;

    logic                 sync1_q, sync2_q, prev_q;
    state_e               state_q;
    logic [BTU_WIDTH-1:0] cnt_q, btu_q;
    logic [1:0]           csize_q;
    logic                 parenb_q, parodd_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           data_q;
    logic                 par_q, any_one_q, s0_q, s1_q;
    logic                 commit_q;
    logic [10:0]          entry_q;

    logic [BTU_WIDTH-1:0] mid;
    logic                 maj, last_data, bit_end, vote;

    assign mid       = btu_q >> 1;
    assign maj       = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
    assign last_data = bit_idx_q == (3'd4 + {1'b0, csize_q});
    assign bit_end   = cnt_q == btu_q;
    assign vote      = cnt_q == mid + BtuOne;

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= StHunt;
            cnt_q     <= '0;
            btu_q     <= '0;
            csize_q   <= '0;
            parenb_q  <= 1'b0;
            parodd_q  <= 1'b0;
            bit_idx_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            any_one_q <= 1'b0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            commit_q  <= 1'b0;
            entry_q   <= '0;
        end else begin
            sync1_q  <= rxd;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            commit_q <= 1'b0;
            if (cnt_q == mid - BtuOne) s0_q <= sync2_q;
            if (cnt_q == mid) s1_q <= sync2_q;
            unique case (state_q)
                StIdleWait: begin
                    if (!sync2_q) begin
                        cnt_q <= '0;
                    end else if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= StHunt;
                    end else begin
                        cnt_q <= cnt_q + BtuOne;
                    end
                end
                StHunt: begin
                    // Line configuration is frozen from the start edge to the end of the frame.
                    btu_q    <= btu;
                    csize_q  <= csize;
                    parenb_q <= parenb;
                    parodd_q <= parodd;
                    if (!sync2_q && prev_q) begin
                        state_q   <= StStart;
                        cnt_q     <= BtuOne;
                        data_q    <= '0;
                        bit_idx_q <= '0;
                        any_one_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (vote && maj) begin
                        state_q <= StHunt;
                    end else if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q + BtuOne;
                    end
                end
                StData: begin
                    if (vote) begin
                        data_q[bit_idx_q] <= maj;
                        if (maj) any_one_q <= 1'b1;
                    end
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (last_data) state_q <= parenb_q ? StParity : StStop;
                    end else begin
                        cnt_q <= cnt_q + BtuOne;
                    end
                end
                StParity: begin
                    if (vote) begin
                        par_q <= maj;
                        if (maj) any_one_q <= 1'b1;
                    end
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + BtuOne;
                    end
                end
                StStop: begin
                    if (vote) begin
                        commit_q <= 1'b1;
                        entry_q  <= {~(any_one_q | maj), ~maj,
                                     parenb_q & ((^data_q ^ par_q) != parodd_q), data_q};
                        cnt_q    <= '0;
                        state_q  <= maj ? StHunt : StIdleWait;
                    end else begin
                        cnt_q <= cnt_q + BtuOne;
                    end
                end
                default: state_q <= StHunt;
            endcase
        end
    end

    logic [10:0]            mem [FIFO_DEPTH];
    logic [LEVEL_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic                   full, pop, push, overrun_q;
    logic [10:0]            head;

    assign level    = wr_ptr_q - rd_ptr_q;
    assign rd_valid = level != '0;
    assign full     = level == Depth;
    assign pop      = rd_en & rd_valid;
    // A same-cycle pop frees the slot the commit needs.
    assign push     = commit_q & (~full | pop);
    assign head     = rd_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
    assign {rd_break, rd_frame_err, rd_parity_err, rd_char} = head;
    assign overrun  = overrun_q;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= entry_q;
    end

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
            if (commit_q && full && !pop) overrun_q <= 1'b1;
            else if (overrun_clr) overrun_q <= 1'b0;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TW = BTU_WIDTH + 6;

    logic [TW-1:0]    tmo_cnt_q, tmo_limit;
    logic [BTU_WIDTH:0] bit_clks;
    logic [3:0]       frame_bits;
    logic             tmo_armed_q, timeout_q;

    assign bit_clks   = {1'b0, btu_q} + (BTU_WIDTH + 1)'(1);
    assign frame_bits = 4'd7 + {2'b0, csize_q} + {3'b0, parenb_q};
    assign tmo_limit  = (TW'(bit_clks) * TW'(frame_bits)) << 2;
    assign timeout    = timeout_q;

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            tmo_cnt_q   <= '0;
            tmo_armed_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (commit_q || pop) begin
                tmo_cnt_q   <= '0;
                tmo_armed_q <= 1'b1;
            end else if (state_q != StHunt || !rd_valid) begin
                tmo_cnt_q <= '0;
            end else if (tmo_armed_q) begin
                if (tmo_cnt_q == tmo_limit - TW'(1)) begin
                    timeout_q   <= 1'b1;
                    tmo_armed_q <= 1'b0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + TW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: framing, parity, voting, glitch rejection,
// overrun with a 4-entry FIFO, short characters and reset during a frame.
module tb_uart_rx_fifo;
    localparam int unsigned BW    = 21;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 3;

    logic          clock = 1'b0;
    logic          reset_in;
    logic [BW-1:0] btu;
    logic [1:0]    csize;
    logic          parenb, parodd, rxd, rd_en, overrun_clr;
    logic          rd_valid, rd_parity_err, rd_frame_err, rd_break, overrun;
    logic [7:0]    rd_char;
    logic [LW-1:0] level;
    logic [11:0]   head;

    int checks = 0;
    int errors = 0;
    int bit_clks = 320;

    always #5 clock = ~clock;

    // {valid, break, frame_err, parity_err, char}
    assign head = {rd_valid, rd_break, rd_frame_err, rd_parity_err, rd_char};

    uart_rx_fifo #(
        .BTU_WIDTH  (BW),
        .FIFO_DEPTH (DEPTH),
        .LEVEL_WIDTH(LW)
    ) dut (
        .clock        (clock),
        .reset_in     (reset_in),
        .btu          (btu),
        .csize        (csize),
        .parenb       (parenb),
        .parodd       (parodd),
        .rxd          (rxd),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_char      (rd_char),
        .rd_parity_err(rd_parity_err),
        .rd_frame_err (rd_frame_err),
        .rd_break     (rd_break),
        .level        (level),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive(1'b0, bit_clks);
        for (int i = 0; i < nbits; i++) drive(d[i], bit_clks);
        if (par_en) drive(par_bit, bit_clks);
        drive(stop_bit, bit_clks);
    endtask

    task automatic pop;
        rd_en = 1'b1;
        @(posedge clock);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic set_line(input int b, input logic [1:0] cs, input logic pe, input logic po);
        btu      = BW'(b);
        bit_clks = b + 1;
        csize    = cs;
        parenb   = pe;
        parodd   = po;
    endtask

    task automatic test_reset;
        reset_in = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if ({head, level, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_held: got head=%h level=%0d ovr=%b want 0", head, level, overrun);
        end
        reset_in = 1'b1;
        drive(1'b1, 20);
        checks++;
        if ({head, level, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_after: got head=%h level=%0d ovr=%b want 0", head, level, overrun);
        end
    endtask

    task automatic test_back_to_back;
        set_line(319, 2'b11, 1'b0, 1'b0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 10);
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL b2b_level: got %0d want 2", level);
        end
        checks++;
        if (head !== 12'h855) begin
            errors++;
            $display("FAIL b2b_first: got %h want 855", head);
        end
        pop();
        checks++;
        if (head !== 12'h8AA) begin
            errors++;
            $display("FAIL b2b_second: got %h want 8AA", head);
        end
        pop();
        checks++;
        if ({head, level} !== '0) begin
            errors++;
            $display("FAIL b2b_empty: got head=%h level=%0d want 0", head, level);
        end
    endtask

    task automatic test_parity;
        // 0x0F has even weight, so odd parity needs a parity bit of 1.
        set_line(319, 2'b11, 1'b1, 1'b1);
        send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b1);
        send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 10);
        checks++;
        if (head !== 12'h80F) begin
            errors++;
            $display("FAIL parity_good: got %h want 80F", head);
        end
        pop();
        checks++;
        if (head !== 12'h90F) begin
            errors++;
            $display("FAIL parity_bad: got %h want 90F", head);
        end
        pop();
    endtask

    task automatic test_glitch;
        set_line(319, 2'b11, 1'b0, 1'b0);
        drive(1'b0, 3 * bit_clks);
        // Single-cycle high pulse landing on the middle of the three vote samples of bit 2.
        drive(1'b0, bit_clks / 2 - 1);
        drive(1'b1, 1);
        drive(1'b0, bit_clks / 2);
        drive(1'b0, 5 * bit_clks);
        drive(1'b1, bit_clks + 10);
        checks++;
        if (head !== 12'h800) begin
            errors++;
            $display("FAIL glitch_vote: got %h want 800", head);
        end
        pop();
    endtask

    task automatic test_start_glitch;
        drive(1'b0, 100);
        drive(1'b1, 800);
        checks++;
        if ({head, level} !== '0) begin
            errors++;
            $display("FAIL start_reject: got head=%h level=%0d want 0", head, level);
        end
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 10);
        checks++;
        if (head !== 12'h83C) begin
            errors++;
            $display("FAIL start_recover: got %h want 83C", head);
        end
        pop();
    endtask

    task automatic test_frame_err;
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4000);
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("FAIL frame_low_level: got %0d want 1", level);
        end
        drive(1'b1, 1000);
        send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 10);
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL frame_level: got %0d want 2", level);
        end
        checks++;
        if (head !== 12'hA0F) begin
            errors++;
            $display("FAIL frame_err_entry: got %h want A0F", head);
        end
        pop();
        checks++;
        if (head !== 12'h8F0) begin
            errors++;
            $display("FAIL frame_clean_entry: got %h want 8F0", head);
        end
        pop();
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 400);
        drive(1'b1, 400);
        checks++;
        if (head !== 12'hE00) begin
            errors++;
            $display("FAIL break_entry: got %h want E00", head);
        end
        pop();
    endtask

    task automatic test_overrun;
        logic [7:0] chars [5];
        chars = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        set_line(31, 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_frame(chars[i], 8, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 40);
        checks++;
        if ({level, overrun} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL ovr_full: got level=%0d ovr=%b want 4 1", level, overrun);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (head !== {4'h8, chars[i]}) begin
                errors++;
                $display("FAIL ovr_entry%0d: got %h want %h", i, head, {4'h8, chars[i]});
            end
            pop();
        end
        checks++;
        if ({rd_valid, overrun} !== 2'b01) begin
            errors++;
            $display("FAIL ovr_sticky: got valid=%b ovr=%b want 0 1", rd_valid, overrun);
        end
        overrun_clr = 1'b1;
        @(posedge clock);
        #1;
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: got %b want 0", overrun);
        end
    endtask

    task automatic test_csize5;
        // A receiver taking 8 bits would read the high stop/idle bits as bits 7:5.
        set_line(319, 2'b00, 1'b0, 1'b0);
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 20);
        checks++;
        if (head !== 12'h81F) begin
            errors++;
            $display("FAIL csize5: got %h want 81F", head);
        end
        pop();
    endtask

    task automatic test_reset_midframe;
        set_line(319, 2'b11, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 10);
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("FAIL midrst_pre: got %0d want 1", level);
        end
        drive(1'b0, bit_clks);
        drive(1'b1, bit_clks);
        drive(1'b0, bit_clks);
        reset_in = 1'b0;
        drive(1'b1, 5);
        reset_in = 1'b1;
        checks++;
        if ({head, level} !== '0) begin
            errors++;
            $display("FAIL midrst_flush: got head=%h level=%0d want 0", head, level);
        end
        drive(1'b1, 400);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 10);
        checks++;
        if ({head, level} !== {12'h8C3, 3'd1}) begin
            errors++;
            $display("FAIL midrst_next: got head=%h level=%0d want 8C3 1", head, level);
        end
    endtask

    initial begin
        rxd         = 1'b1;
        rd_en       = 1'b0;
        overrun_clr = 1'b0;
        set_line(319, 2'b11, 1'b0, 1'b0);
        test_reset();
        test_back_to_back();
        test_parity();
        test_glitch();
        test_start_glitch();
        test_frame_err();
        test_overrun();
        test_csize5();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
